// File: rtl/jtframe_bram_bank.sv
// Block-RAM responder for a jtframe_sdram64 bank port: rd/wr -> ack -> dst/dok -> rdy handshake.
// Optional macro JTFRAME_BRAMBANK_RANDWAIT_EN adds an LFSR-driven 0..3 cycle delay before ack.
module jtframe_bram_bank #(
  parameter int    AW      = 22,
  parameter int    MEMAW   = 12,
  parameter int    BURST   = 2,
  parameter int    LATENCY = 2,
  parameter int    INITLEN = 16,
  parameter string MEMFILE = ""
) (
  input  logic          clk,
  input  logic          rst,
  output logic          init,
  input  logic [AW-1:0] addr,
  input  logic          rd,
  input  logic          wr,
  input  logic [15:0]   din,
  input  logic [1:0]    dsn,
  output logic          ack,
  output logic          dst,
  output logic          dok,
  output logic          rdy,
  output logic [15:0]   dout
);

  localparam int ICW = $clog2(INITLEN + 1);
  localparam int WCW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_WAIT, ST_BURST, ST_WRITE} state_t;

  state_t           st;
  logic [ICW-1:0]   icnt;
  logic [WCW-1:0]   wcnt;
  logic [2:0]       widx;
  logic [MEMAW-1:0] a_reg;
  logic [MEMAW-1:0] rd_a;
  logic [15:0]      din_r;
  logic [1:0]       dsn_r;
  logic [15:0]      q;
  logic             go;
  logic [15:0]      mem [2**MEMAW];

  logic unused_bits;
  assign unused_bits = ^{1'b0, addr};

`ifdef JTFRAME_BRAMBANK_RANDWAIT_EN
  logic [15:0] lfsr;
  logic        armed;
  logic [1:0]  rw_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= 16'hACE1;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // The first sighting of a request samples the LFSR; a zero draw acks without delay
  assign go = (rd | wr) && (armed ? (rw_cnt == 2'd0) : (lfsr[1:0] == 2'd0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed  <= 1'b0;
      rw_cnt <= '0;
    end else if (st != ST_IDLE || !(rd | wr) || go) begin
      armed  <= 1'b0;
    end else if (!armed) begin
      armed  <= 1'b1;
      rw_cnt <= lfsr[1:0] - 2'd1;
    end else begin
      rw_cnt <= rw_cnt - 2'd1;
    end
  end
`else
  assign go = rd | wr;
`endif

  // The RAM output q lags rd_a by one cycle, so the address runs one word ahead of dout
  always_comb begin
    rd_a = a_reg;
    case (st)
      ST_IDLE:  rd_a = addr[MEMAW-1:0];
      ST_WAIT:  rd_a = (wcnt == '0) ? a_reg + MEMAW'(1) : a_reg;
      ST_BURST: rd_a = a_reg + MEMAW'(widx) + MEMAW'(1);
      default:  rd_a = a_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    q <= mem[rd_a];
    if (st == ST_WRITE) begin
      if (!dsn_r[1]) mem[a_reg][15:8] <= din_r[15:8];
      if (!dsn_r[0]) mem[a_reg][7:0]  <= din_r[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st    <= ST_INIT;
      init  <= 1'b1;
      icnt  <= '0;
      wcnt  <= '0;
      widx  <= '0;
      a_reg <= '0;
      din_r <= '0;
      dsn_r <= '1;
      ack   <= 1'b0;
      dst   <= 1'b0;
      dok   <= 1'b0;
      rdy   <= 1'b0;
      dout  <= '0;
    end else begin
      ack <= 1'b0;
      dst <= 1'b0;
      dok <= 1'b0;
      rdy <= 1'b0;
      case (st)
        ST_INIT: begin
          if (icnt == ICW'(INITLEN - 1)) begin
            init <= 1'b0;
            st   <= ST_IDLE;
          end else begin
            icnt <= icnt + ICW'(1);
          end
        end
        ST_IDLE: begin
          if (go) begin
            ack   <= 1'b1;
            a_reg <= addr[MEMAW-1:0];
            din_r <= din;
            dsn_r <= dsn;
            wcnt  <= WCW'(LATENCY - 1);
            st    <= wr ? ST_WRITE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wcnt == '0) begin
            dout <= q;
            dst  <= 1'b1;
            dok  <= 1'b1;
            widx <= 3'd1;
            if (BURST == 1) begin
              rdy <= 1'b1;
              st  <= ST_IDLE;
            end else begin
              st  <= ST_BURST;
            end
          end else begin
            wcnt <= wcnt - WCW'(1);
          end
        end
        ST_BURST: begin
          dout <= q;
          dok  <= 1'b1;
          widx <= widx + 3'd1;
          if (widx == 3'(BURST - 1)) begin
            rdy <= 1'b1;
            st  <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          rdy <= 1'b1;
          st  <= ST_IDLE;
        end
        default: st <= ST_INIT;
      endcase
    end
  end

endmodule
